// File: rtl/ir_pkg.sv
// Shared types and presets for the IR packet transmitter.
// Holds the colour and state encodings, the per-colour burst sizes
// (start/gap/select/assert/deassert, in carrier periods), and the carrier
// half-period calculation.
package ir_pkg;

    localparam int unsigned BURST_W = 8;

    typedef enum logic [1:0] {
        COL_BLUE   = 2'd0,
        COL_YELLOW = 2'd1,
        COL_GREEN  = 2'd2,
        COL_RED    = 2'd3
    } colour_t;

    typedef struct packed {
        logic [BURST_W-1:0] start;
        logic [BURST_W-1:0] gap;
        logic [BURST_W-1:0] select;
        logic [BURST_W-1:0] asserted;
        logic [BURST_W-1:0] deasserted;
    } burst_cfg_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_GAP,
        ST_SELECT,
        ST_DIR,
        ST_END,
        ST_WAIT
    } state_t;

    // Four-entry burst-size table indexed by colour.
    function automatic burst_cfg_t burst_preset(input colour_t c);
        burst_cfg_t cfg;
        case (c)
            COL_YELLOW: cfg = '{8'd88,  8'd40, 8'd22, 8'd44, 8'd22};
            COL_GREEN:  cfg = '{8'd88,  8'd40, 8'd44, 8'd44, 8'd22};
            COL_RED:    cfg = '{8'd192, 8'd24, 8'd24, 8'd48, 8'd24};
            default:    cfg = '{8'd191, 8'd25, 8'd47, 8'd47, 8'd22};
        endcase
        return cfg;
    endfunction

    // Carrier half-period in clocks, truncated: clk_freq / (2 * f_carrier).
    function automatic int unsigned half_period(input int unsigned clk_freq, input colour_t c);
        int unsigned h;
        case (c)
            COL_YELLOW: h = clk_freq / 80_000;
            COL_GREEN:  h = clk_freq / 75_000;
            default:    h = clk_freq / 72_000;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/ir_packet_tx_if.sv
// Request/status bundle between the IR register block (master) and the
// packet transmitter (slave).
//   command     - direction bits, MSB sent first
//   colour      - car colour preset
//   send_packet - start request
//   repeat_en   - periodic retransmit enable
//   busy, done  - transmitter status
//   ir_led      - modulated LED drive
interface ir_packet_tx_if
    import ir_pkg::*;
#(
    parameter int unsigned NUM_CMD = 4
);
    logic [NUM_CMD-1:0] command;
    colour_t            colour;
    logic               send_packet;
    logic               repeat_en;
    logic               busy;
    logic               done;
    logic               ir_led;

    modport master (
        output command, colour, send_packet, repeat_en,
        input  busy, done, ir_led
    );

    modport slave (
        input  command, colour, send_packet, repeat_en,
        output busy, done, ir_led
    );
endinterface

// File: rtl/ir_carrier_gen.sv
// Carrier divider for the IR LED.
// Counts 0..HALF-1 and toggles phase on each wrap; restart forces count=0,
// phase=1. period_tick_c marks the cycle whose edge takes phase 0->1, i.e.
// the last cycle of each full carrier period.
//   clk, resetn    - clock, synchronous active-low reset
//   restart        - restart carrier phase
//   colour         - selects the half-period
//   phase          - registered carrier phase
//   period_tick_c  - end-of-period strobe (combinational)
module ir_carrier_gen
    import ir_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000
) (
    input  logic    clk,
    input  logic    resetn,
    input  logic    restart,
    input  colour_t colour,
    output logic    phase,
    output logic    period_tick_c
);
    localparam int unsigned HALF_BLUE   = half_period(CLK_FREQ, COL_BLUE);
    localparam int unsigned HALF_YELLOW = half_period(CLK_FREQ, COL_YELLOW);
    localparam int unsigned HALF_GREEN  = half_period(CLK_FREQ, COL_GREEN);
    localparam int unsigned HALF_RED    = half_period(CLK_FREQ, COL_RED);
    // 36 kHz (blue/red) is the lowest carrier, so it has the longest half-period.
    localparam int unsigned HALF_MAX    = HALF_BLUE;
    localparam int unsigned CW          = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

    logic [CW-1:0] count;
    logic [CW-1:0] half_m1;
    logic          wrap_c;

    // Per-colour terminal count.
    always_comb begin
        half_m1 = CW'(HALF_BLUE - 1);
        case (colour)
            COL_YELLOW: half_m1 = CW'(HALF_YELLOW - 1);
            COL_GREEN:  half_m1 = CW'(HALF_GREEN - 1);
            COL_RED:    half_m1 = CW'(HALF_RED - 1);
            default:    half_m1 = CW'(HALF_BLUE - 1);
        endcase
        wrap_c        = (count == half_m1);
        period_tick_c = wrap_c && !phase;
    end

    // Divider and phase register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
            phase <= 1'b0;
        end else if (restart) begin
            count <= '0;
            phase <= 1'b1;
        end else if (wrap_c) begin
            count <= '0;
            phase <= ~phase;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/ir_packet_tx.sv
// IR packet transmitter.
// Sends START, GAP, SELECT, GAP, then NUM_CMD x (DIR, GAP) bursts of a
// colour-dependent carrier, pulses DONE, and optionally repeats every
// REPEAT_MS measured start to start.
//   CLK, RESETN - clock, synchronous active-low reset
//   bus         - request/status bundle (slave side)
module ir_packet_tx
    import ir_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned NUM_CMD   = 4,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned REPEAT_MS = 100
) (
    input  logic           CLK,
    input  logic           RESETN,
    ir_packet_tx_if.slave  bus
);
    localparam int unsigned REPEAT_CYCLES = CLK_FREQ / 1000 * REPEAT_MS;
    localparam int unsigned TMR_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam int unsigned FLD_W = (NUM_CMD > 1) ? $clog2(NUM_CMD) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REPEAT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};

    state_t             state_q, state_d;
    state_t             gap_next_q, gap_next_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FLD_W-1:0]   field_q, field_d;
    logic [NUM_CMD-1:0] cmd_q, cmd_d;
    colour_t            colour_q, colour_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               led_q, led_d;

    logic               restart_c;
    logic               phase;
    logic               period_tick_c;
    burst_cfg_t         cfg_c;
    logic [CNT_W-1:0]   size_c;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic               in_region_c;
    logic               in_burst_c;
    logic               region_end_c;

    ir_carrier_gen #(
        .CLK_FREQ(CLK_FREQ)
    ) u_carrier (
        .clk          (CLK),
        .resetn       (RESETN),
        .restart      (restart_c),
        .colour       (colour_q),
        .phase        (phase),
        .period_tick_c(period_tick_c)
    );

    // Size of the current region and end-of-region detect.
    always_comb begin
        cfg_c       = burst_preset(colour_q);
        size_c      = '0;
        in_region_c = 1'b1;
        in_burst_c  = 1'b0;
        case (state_q)
            ST_START:  begin size_c = CNT_W'(cfg_c.start);  in_burst_c = 1'b1; end
            ST_GAP:    size_c = CNT_W'(cfg_c.gap);
            ST_SELECT: begin size_c = CNT_W'(cfg_c.select); in_burst_c = 1'b1; end
            ST_DIR: begin
                size_c     = cmd_q[field_q] ? CNT_W'(cfg_c.asserted) : CNT_W'(cfg_c.deasserted);
                in_burst_c = 1'b1;
            end
            default:   in_region_c = 1'b0;
        endcase
        cnt_inc_c    = cnt_q + CNT_W'(1);
        region_end_c = in_region_c && period_tick_c && (cnt_inc_c == size_c);
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        gap_next_d = gap_next_q;
        cnt_d      = cnt_q;
        field_d    = field_q;
        cmd_d      = cmd_q;
        colour_d   = colour_q;
        tmr_d      = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + TMR_W'(1);
        restart_c  = 1'b0;

        if (in_region_c && period_tick_c) begin
            cnt_d = cnt_inc_c;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.send_packet) restart_c = 1'b1;
            end
            ST_START: begin
                if (region_end_c) begin
                    state_d    = ST_GAP;
                    gap_next_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (region_end_c) begin
                    state_d    = ST_GAP;
                    gap_next_d = ST_DIR;
                end
            end
            ST_DIR: begin
                if (region_end_c) begin
                    state_d = ST_GAP;
                    if (field_q == '0) begin
                        gap_next_d = ST_END;
                    end else begin
                        gap_next_d = ST_DIR;
                        field_d    = field_q - FLD_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (region_end_c) state_d = gap_next_q;
            end
            ST_END: begin
                // An overdue repeat restarts straight from END.
                if (!bus.repeat_en)          state_d   = ST_IDLE;
                else if (tmr_q >= TMR_LAST)  restart_c = 1'b1;
                else                         state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.repeat_en)          state_d   = ST_IDLE;
                else if (tmr_q >= TMR_LAST)  restart_c = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (region_end_c) cnt_d = '0;

        if (restart_c) begin
            state_d    = ST_START;
            gap_next_d = ST_SELECT;
            cnt_d      = '0;
            field_d    = FLD_W'(NUM_CMD - 1);
            cmd_d      = bus.command;
            colour_d   = bus.colour;
            tmr_d      = '0;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_END);
        led_d  = phase && in_burst_c;
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q    <= ST_IDLE;
            gap_next_q <= ST_SELECT;
            cnt_q      <= '0;
            field_q    <= '0;
            cmd_q      <= '0;
            colour_q   <= COL_BLUE;
            tmr_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_next_q <= gap_next_d;
            cnt_q      <= cnt_d;
            field_q    <= field_d;
            cmd_q      <= cmd_d;
            colour_q   <= colour_d;
            tmr_q      <= tmr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            led_q      <= led_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.ir_led = led_q;

endmodule
